ahbmtx_l1_input_stage: RTL and testbench
========================================

Name: ahbmtx_l1_input_stage

Overview:
- Slave-side input stage of the level-1 AHB bus matrix. Sits directly upstream of the per-input-port address decoder (decode, default-slave and read-data muxing stage).
- Captures a master's address-phase controls into a one-entry holding register when the selected output stage cannot accept them (decoder active low). Replays the held transfer until accepted.
- Generates the master-facing HREADYOUTS/HRESPS, merging the decoder's data-phase response with hold-induced wait states.

Parameters:
- ADDR_W, 32, address width; decoder consumes bits [31:10].
- MST_W, 4, HMASTER width.

Ports:
- HCLK  in  1  AHB system clock.
- HRESET  in  1  synchronous, active-high reset.
- HSELS  in  1  slave-port select from master.
- HADDRS  in  ADDR_W  address.
- HTRANSS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITES  in  1  write.
- HSIZES  in  3  size.
- HBURSTS  in  3  burst.
- HPROTS  in  4  protection.
- HMASTERS  in  MST_W  master id.
- HMASTLOCKS  in  1  locked transfer.
- HREADYS  in  1  bus-level HREADY seen by this port.
- active_in  in  1  decoder active: selected output stage accepts this cycle.
- readyout_in  in  1  decoder HREADYOUTS (data-phase ready).
- resp_in  in  2  decoder HRESPS.
- sel_in  out  1  select to decoder.
- addr_in  out  ADDR_W  address to decoder.
- trans_in  out  2  HTRANS to decoder.
- write_in, size_in, burst_in, prot_in, master_in, mastlock_in  out  1/3/3/4/MST_W/1  controls to decoder.
- held_tran_in  out  1  presented transfer comes from the holding register.
- HREADYOUTS  out  1  ready to master.
- HRESPS  out  2  response to master.

Behaviour:
- State: hold_valid (holding register full), data_phase (accepted transfer in data phase), plus the registered control set.
- Reset (HRESET=1 at posedge):
  - hold_valid=0, data_phase=0, holding register cleared to IDLE/zero.
  - Outputs after reset: HREADYOUTS=1, HRESPS=00, held_tran_in=0, trans_in=HTRANSS pass-through.
  - Reset mid-hold discards the held transfer; it is not replayed.
- new_tran = HSELS & HREADYS & HTRANSS[1].
- Presentation mux:
  - hold_valid=0: sel_in=HSELS and all *_in outputs pass HADDRS/controls combinationally (zero latency).
  - hold_valid=1: sel_in=1 and all *_in outputs come from the holding register; held_tran_in=1.
  - A held SEQ is presented as trans_in=NONSEQ with burst_in=INCR (001). Other held fields are unchanged.
- Load: hold_valid=0 & new_tran & ~active_in.
  - Capture all controls next posedge; hold_valid<=1.
- Release: hold_valid=1 & active_in.
  - hold_valid<=0, data_phase<=1.
  - Master inputs are ignored while hold_valid=1: HREADYOUTS=0, so the master is stalled.
- Direct accept: hold_valid=0 & new_tran & active_in → data_phase<=1.
- data_phase clears when readyout_in=1 and no accept or release occurs in the same cycle. A simultaneous accept or release keeps data_phase=1 (back-to-back).
- HREADYOUTS:
  - 0 when hold_valid.
  - else readyout_in when data_phase.
  - else 1.
- HRESPS: resp_in when data_phase & ~hold_valid, else 00.
- ERROR handling: the two-cycle ERROR response (resp=01 with readyout 0 then 1) passes straight through. After the first ERROR cycle, if the master drives IDLE, no load occurs.
- IDLE and BUSY never load or set data_phase. HSELS=0 never loads.

Test Plan:
- Direct path: HSELS=1, NONSEQ, HADDRS=0x0000_0100, active_in=1, readyout_in=1 → trans_in=10 same cycle, held_tran_in=0, data_phase next cycle, HREADYOUTS=1.
- Hold and replay: NONSEQ write to 0x2000_0400, active_in=0 for 3 cycles then 1 → hold_valid next cycle, HREADYOUTS=0 for 3 cycles, addr_in=0x2000_0400 and write_in=1 held, held_tran_in=1; after release HREADYOUTS follows readyout_in.
- SEQ conversion: INCR4 beat SEQ to 0x0000_0008 blocked (active_in=0) → held presentation trans_in=10, burst_in=001.
- Wait states: data_phase with readyout_in=0 for 2 cycles, resp_in=00 → HREADYOUTS=0,0,1; no load while HREADYS=0.
- Error: resp_in=01 with readyout_in=0 then 1 → HRESPS=01 both cycles, HREADYOUTS=0 then 1; the following IDLE leaves hold_valid=0.
- Reset mid-hold: hold_valid=1, HRESET=1 for one posedge → HREADYOUTS=1, held_tran_in=0, HRESPS=00 next cycle; the held transfer is never presented again.

Source files
------------

// File: rtl/ahbmtx_l1_input_stage_if.sv
// Bus-side signal bundle for the level-1 matrix input stage: master-facing AHB
// slave port plus the link to the per-port address decoder.
interface ahbmtx_l1_input_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MST_W  = 4
);
    // Master-facing AHB slave port
    logic              HSELS;
    logic [ADDR_W-1:0] HADDRS;
    logic [1:0]        HTRANSS;
    logic              HWRITES;
    logic [2:0]        HSIZES;
    logic [2:0]        HBURSTS;
    logic [3:0]        HPROTS;
    logic [MST_W-1:0]  HMASTERS;
    logic              HMASTLOCKS;
    logic              HREADYS;
    logic              HREADYOUTS;
    logic [1:0]        HRESPS;

    // Decoder link
    logic              active_in;
    logic              readyout_in;
    logic [1:0]        resp_in;
    logic              sel_in;
    logic [ADDR_W-1:0] addr_in;
    logic [1:0]        trans_in;
    logic              write_in;
    logic [2:0]        size_in;
    logic [2:0]        burst_in;
    logic [3:0]        prot_in;
    logic [MST_W-1:0]  master_in;
    logic              mastlock_in;
    logic              held_tran_in;

    // Seen from the input stage itself
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTERS, HMASTLOCKS, HREADYS,
               active_in, readyout_in, resp_in,
        output HREADYOUTS, HRESPS,
               sel_in, addr_in, trans_in, write_in, size_in, burst_in,
               prot_in, master_in, mastlock_in, held_tran_in
    );

    // Seen from the environment driving the stage (master plus decoder)
    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTERS, HMASTLOCKS, HREADYS,
               active_in, readyout_in, resp_in,
        input  HREADYOUTS, HRESPS,
               sel_in, addr_in, trans_in, write_in, size_in, burst_in,
               prot_in, master_in, mastlock_in, held_tran_in
    );
endinterface

// File: rtl/ahbmtx_l1_input_stage.sv
// Level-1 AHB matrix input stage: holds a blocked address phase, replays it to
// the decoder until accepted and merges hold wait states into HREADYOUTS.
module ahbmtx_l1_input_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MST_W  = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    ahbmtx_l1_input_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] BURST_INCR = 3'b001;

    logic              hold_valid;
    logic              data_phase;
    logic [ADDR_W-1:0] hold_addr;
    htrans_e           hold_trans;
    logic              hold_write;
    logic [2:0]        hold_size;
    logic [2:0]        hold_burst;
    logic [3:0]        hold_prot;
    logic [MST_W-1:0]  hold_master;
    logic              hold_mastlock;

    logic new_tran;
    logic load_hold;
    logic rel_hold;
    logic accept;

    assign new_tran  = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
    assign load_hold = ~hold_valid & new_tran & ~bus.active_in;
    assign rel_hold  =  hold_valid & bus.active_in;
    assign accept    = ~hold_valid & new_tran & bus.active_in;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hold_valid    <= 1'b0;
            data_phase    <= 1'b0;
            hold_addr     <= '0;
            hold_trans    <= TRANS_IDLE;
            hold_write    <= 1'b0;
            hold_size     <= '0;
            hold_burst    <= '0;
            hold_prot     <= '0;
            hold_master   <= '0;
            hold_mastlock <= 1'b0;
        end else begin
            if (load_hold) begin
                hold_valid    <= 1'b1;
                hold_addr     <= bus.HADDRS;
                hold_trans    <= htrans_e'(bus.HTRANSS);
                hold_write    <= bus.HWRITES;
                hold_size     <= bus.HSIZES;
                hold_burst    <= bus.HBURSTS;
                hold_prot     <= bus.HPROTS;
                hold_master   <= bus.HMASTERS;
                hold_mastlock <= bus.HMASTLOCKS;
            end else if (rel_hold) begin
                hold_valid <= 1'b0;
            end

            // An accept or release in the completing cycle keeps the data phase open back-to-back
            if (accept || rel_hold) begin
                data_phase <= 1'b1;
            end else if (bus.readyout_in) begin
                data_phase <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.sel_in       = bus.HSELS;
        bus.addr_in      = bus.HADDRS;
        bus.trans_in     = bus.HTRANSS;
        bus.write_in     = bus.HWRITES;
        bus.size_in      = bus.HSIZES;
        bus.burst_in     = bus.HBURSTS;
        bus.prot_in      = bus.HPROTS;
        bus.master_in    = bus.HMASTERS;
        bus.mastlock_in  = bus.HMASTLOCKS;
        bus.held_tran_in = 1'b0;
        if (hold_valid) begin
            bus.sel_in       = 1'b1;
            bus.addr_in      = hold_addr;
            bus.trans_in     = hold_trans;
            bus.write_in     = hold_write;
            bus.size_in      = hold_size;
            bus.burst_in     = hold_burst;
            bus.prot_in      = hold_prot;
            bus.master_in    = hold_master;
            bus.mastlock_in  = hold_mastlock;
            bus.held_tran_in = 1'b1;
            // A replayed SEQ has lost its burst context downstream, so restart it as INCR
            if (hold_trans == TRANS_SEQ) begin
                bus.trans_in = TRANS_NONSEQ;
                bus.burst_in = BURST_INCR;
            end
        end
    end

    always_comb begin
        bus.HREADYOUTS = 1'b1;
        bus.HRESPS     = 2'b00;
        if (hold_valid) begin
            bus.HREADYOUTS = 1'b0;
        end else if (data_phase) begin
            bus.HREADYOUTS = bus.readyout_in;
            bus.HRESPS     = bus.resp_in;
        end
    end

endmodule

// File: tb/tb_ahbmtx_l1_input_stage.sv
// Scoreboard bench for ahbmtx_l1_input_stage: directed per-cycle vectors push
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_ahbmtx_l1_input_stage;

    logic HCLK;
    logic HRESET;

    ahbmtx_l1_input_stage_if #(.ADDR_W(32), .MST_W(4)) bus ();

    ahbmtx_l1_input_stage #(.ADDR_W(32), .MST_W(4)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct {
        string       name;
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  burst;
        logic [3:0]  master;
        logic        held;
        logic        ready;
        logic [1:0]  resp;
    } exp_t;

    exp_t sbq[$];
    int   n_pass;
    int   n_total;
    bit   stim_done;

    function automatic exp_t ex(string n, logic sel, logic [31:0] a, logic [1:0] t,
                                logic w, logic [2:0] b, logic [3:0] m,
                                logic held, logic rdy, logic [1:0] resp);
        exp_t e;
        e.name = n; e.sel = sel; e.addr = a; e.trans = t; e.write = w;
        e.burst = b; e.master = m; e.held = held; e.ready = rdy; e.resp = resp;
        return e;
    endfunction

    // Drive one cycle of inputs just after the edge and queue what the DUT must show
    task automatic step(input logic rst, input logic sel, input logic hrdy,
                        input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [2:0] b, input logic [3:0] m,
                        input logic act, input logic rdyo, input logic [1:0] rsp,
                        input exp_t e);
        @(posedge HCLK);
        #1;
        HRESET          = rst;
        bus.HSELS       = sel;
        bus.HREADYS     = hrdy;
        bus.HADDRS      = a;
        bus.HTRANSS     = t;
        bus.HWRITES     = w;
        bus.HBURSTS     = b;
        bus.HMASTERS    = m;
        bus.active_in   = act;
        bus.readyout_in = rdyo;
        bus.resp_in     = rsp;
        sbq.push_back(e);
    endtask

    task automatic chk(input string n, input string f, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s.%s got %h expected %h", n, f, act, exp);
        else
            n_pass++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk(e.name, "sel_in",       {31'd0, bus.sel_in},       {31'd0, e.sel});
                chk(e.name, "addr_in",      bus.addr_in,               e.addr);
                chk(e.name, "trans_in",     {30'd0, bus.trans_in},     {30'd0, e.trans});
                chk(e.name, "write_in",     {31'd0, bus.write_in},     {31'd0, e.write});
                chk(e.name, "burst_in",     {29'd0, bus.burst_in},     {29'd0, e.burst});
                chk(e.name, "master_in",    {28'd0, bus.master_in},    {28'd0, e.master});
                chk(e.name, "held_tran_in", {31'd0, bus.held_tran_in}, {31'd0, e.held});
                chk(e.name, "HREADYOUTS",   {31'd0, bus.HREADYOUTS},   {31'd0, e.ready});
                chk(e.name, "HRESPS",       {30'd0, bus.HRESPS},       {30'd0, e.resp});
            end
        end
    end

    initial begin : stimulus
        n_pass = 0; n_total = 0; stim_done = 0;
        HRESET = 1'b1;
        bus.HSELS = 0; bus.HREADYS = 1; bus.HADDRS = '0; bus.HTRANSS = 2'b00;
        bus.HWRITES = 0; bus.HSIZES = 3'b010; bus.HBURSTS = 3'b000; bus.HPROTS = 4'h3;
        bus.HMASTERS = 4'h5; bus.HMASTLOCKS = 0;
        bus.active_in = 0; bus.readyout_in = 1; bus.resp_in = 2'b00;

        //    rst sel hrdy addr          tr     w  burst   mst   act rdyo resp
        step(1, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("reset0",   0, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        step(1, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("reset1",   0, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        // Direct path
        step(0, 1, 1, 32'h0000_0100, 2'b10, 0, 3'b000, 4'h5, 1, 1, 2'b00,
             ex("direct",   1, 32'h0000_0100, 2'b10, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("direct_dp",0, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        // Hold and replay: blocked for three cycles, master inputs change meanwhile
        step(0, 1, 1, 32'h2000_0400, 2'b10, 1, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("hold_req", 1, 32'h2000_0400, 2'b10, 1, 3'b000, 4'h5, 0, 1, 2'b00));
        step(0, 1, 1, 32'hDEAD_0000, 2'b00, 0, 3'b000, 4'hA, 0, 1, 2'b00,
             ex("hold_w1",  1, 32'h2000_0400, 2'b10, 1, 3'b000, 4'h5, 1, 0, 2'b00));
        step(0, 1, 1, 32'hDEAD_0000, 2'b00, 0, 3'b000, 4'hA, 0, 1, 2'b00,
             ex("hold_w2",  1, 32'h2000_0400, 2'b10, 1, 3'b000, 4'h5, 1, 0, 2'b00));
        step(0, 1, 1, 32'hDEAD_0000, 2'b00, 0, 3'b000, 4'hA, 1, 1, 2'b00,
             ex("hold_rel", 1, 32'h2000_0400, 2'b10, 1, 3'b000, 4'h5, 1, 0, 2'b00));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 0, 2'b00,
             ex("replay_dp0",0,32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 0, 2'b00));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("replay_dp1",0,32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        // SEQ conversion
        step(0, 1, 1, 32'h0000_0008, 2'b11, 0, 3'b011, 4'h5, 0, 1, 2'b00,
             ex("seq_req",  1, 32'h0000_0008, 2'b11, 0, 3'b011, 4'h5, 0, 1, 2'b00));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 1, 1, 2'b00,
             ex("seq_held", 1, 32'h0000_0008, 2'b10, 0, 3'b001, 4'h5, 1, 0, 2'b00));
        // Wait states, HREADYS low blocks any load
        step(0, 1, 0, 32'h0000_0300, 2'b10, 0, 3'b000, 4'h5, 0, 0, 2'b00,
             ex("wait1",    1, 32'h0000_0300, 2'b10, 0, 3'b000, 4'h5, 0, 0, 2'b00));
        step(0, 1, 0, 32'h0000_0300, 2'b10, 0, 3'b000, 4'h5, 0, 0, 2'b00,
             ex("wait2",    1, 32'h0000_0300, 2'b10, 0, 3'b000, 4'h5, 0, 0, 2'b00));
        step(0, 1, 1, 32'h0000_0300, 2'b10, 0, 3'b000, 4'h5, 1, 1, 2'b00,
             ex("wait_done",1, 32'h0000_0300, 2'b10, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        // Two-cycle ERROR, master drops to IDLE after the first cycle
        step(0, 1, 0, 32'h0000_0400, 2'b10, 0, 3'b000, 4'h5, 0, 0, 2'b01,
             ex("err1",     1, 32'h0000_0400, 2'b10, 0, 3'b000, 4'h5, 0, 0, 2'b01));
        step(0, 1, 1, 32'h0000_0400, 2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b01,
             ex("err2",     1, 32'h0000_0400, 2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b01));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b01,
             ex("err_after",0, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        // Reset mid-hold
        step(0, 1, 1, 32'h5000_0000, 2'b10, 1, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("rh_req",   1, 32'h5000_0000, 2'b10, 1, 3'b000, 4'h5, 0, 1, 2'b00));
        step(1, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("rh_held",  1, 32'h5000_0000, 2'b10, 1, 3'b000, 4'h5, 1, 0, 2'b00));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("rh_after", 0, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 1, 1, 2'b00,
             ex("rh_gone",  0, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        // Unselected NONSEQ and BUSY never load nor open a data phase
        step(0, 0, 1, 32'h0000_0600, 2'b10, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("unsel",    0, 32'h0000_0600, 2'b10, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        step(0, 1, 1, 32'h0000_0700, 2'b01, 0, 3'b000, 4'h5, 0, 1, 2'b00,
             ex("busy",     1, 32'h0000_0700, 2'b01, 0, 3'b000, 4'h5, 0, 1, 2'b00));
        step(0, 0, 1, 32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 0, 2'b00,
             ex("busy_after",0,32'h0,         2'b00, 0, 3'b000, 4'h5, 0, 1, 2'b00));

        stim_done = 1;
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge HCLK);
        if (sbq.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        @(posedge HCLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
